// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream handshake plus instruction-memory write port.
interface imem_boot_loader_if #(parameter int ADDR_WIDTH = 10);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0] mem_wdata;
  modport slave (input in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
  modport master (output in_data, in_valid, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, XOR-checksummed image into instruction memory
// and holds the core stalled until the checksum verifies.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input logic clock,
  input logic reset_n,
  input logic start,
  imem_boot_loader_if.slave bus,
  output logic core_hold,
  output logic done,
  output logic error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_t;
  state_t state;
  logic [15:0] len;
  logic [1:0] idx;
  logic [7:0] acc;
  logic [23:0] wbuf;
  logic xfer;
  logic [16:0] n_len;
  assign xfer = bus.in_valid & bus.in_ready;
  assign n_len = {1'b0, bus.in_data, len[7:0]};
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      bus.in_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      core_hold <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      words_loaded <= '0;
      len <= '0;
      idx <= '0;
      acc <= '0;
      wbuf <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= LEN_LO;
          bus.in_ready <= 1'b1;
          core_hold <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          words_loaded <= '0;
          acc <= '0;
          idx <= '0;
        end
        LEN_LO: if (xfer) begin
          len[7:0] <= bus.in_data;
          state <= LEN_HI;
        end
        LEN_HI: if (xfer) begin
          len[15:8] <= bus.in_data;
          if (n_len > 17'(MAX_WORDS)) begin
            state <= ERR;
            bus.in_ready <= 1'b0;
            error <= 1'b1;
          end else begin
            state <= (n_len == 17'd0) ? CHECK : DATA;
          end
        end
        DATA: if (xfer) begin
          acc <= acc ^ bus.in_data;
          idx <= idx + 2'd1;
          // bytes shift in from the top so byte k lands at bits [8k+7:8k]
          wbuf <= {bus.in_data, wbuf[23:8]};
          if (idx == 2'd3) begin
            bus.mem_we <= 1'b1;
            bus.mem_addr <= words_loaded[ADDR_WIDTH-1:0];
            bus.mem_wdata <= {bus.in_data, wbuf};
            words_loaded <= words_loaded + 1'b1;
            if (17'(words_loaded) + 17'd1 == {1'b0, len}) state <= CHECK;
          end
        end
        CHECK: if (xfer) begin
          bus.in_ready <= 1'b0;
          if (bus.in_data == acc) begin
            state <= DONE;
            done <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
